escritor_rastro: RTL and testbench
==================================

ESCRITOR_RASTRO -- requirements
Module: escritor_rastro

Interface
REQ-001 The module SHALL have parameter LARGURA, default 640, meaning screen width in pixels and RAM row stride.
REQ-002 The module SHALL have parameter ALTURA, default 480, meaning screen height in pixels.
REQ-003 The module SHALL have parameter TAM_BLOCO, default 8, meaning side of the square player block in pixels.
REQ-004 Port CLOCK_50  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port limpar  input  1  request to clear the whole trail RAM to 0; sampled every edge.
REQ-007 Port desenha_req  input  1  request to write one player block.
REQ-008 Port coord_x  input  10  block top-left x, sampled on acceptance.
REQ-009 Port coord_y  input  10  block top-left y, sampled on acceptance.
REQ-010 Port cor  input  8  trail code written for each block pixel (e.g. 8'h01 player 1), sampled on acceptance.
REQ-011 Port wraddress  output  19  trail RAM write address, x + y*LARGURA.
REQ-012 Port data  output  8  trail RAM write data.
REQ-013 Port wren  output  1  trail RAM write enable.
REQ-014 Port ocupado  output  1  high while state is not IDLE.
REQ-015 Port pronto  output  1  one-cycle pulse marking completion of a clear or a draw.

Function
REQ-016 All outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-017 The FSM SHALL have exactly three states: IDLE, LIMPA, DESENHA.
REQ-018 In IDLE with limpar=1 at an edge: go to LIMPA; at that same edge wren=1, wraddress=0, data=0.
REQ-019 In IDLE with limpar=0 and desenha_req=1 at an edge: latch coord_x, coord_y, cor; go to DESENHA; at that edge emit first pixel (x, y).
REQ-020 limpar SHALL take priority over a simultaneous desenha_req.
REQ-021 LIMPA SHALL write data=0 to addresses 0 .. LARGURA*ALTURA-1 (0..307199 default) on consecutive edges, ascending by 1, one write per cycle.
REQ-022 DESENHA SHALL write TAM_BLOCO*TAM_BLOCO pixels on consecutive edges, row-major: columns x..x+TAM_BLOCO-1 within row y, then row y+1, through row y+TAM_BLOCO-1.
REQ-023 Address SHALL be computed in 19-bit unsigned arithmetic; no truncation for in-range coordinates.
REQ-024 Pixels with column >= LARGURA or row >= ALTURA SHALL be clipped: wren=0 for that cycle, sequencing still advances, so a draw always takes exactly TAM_BLOCO*TAM_BLOCO cycles.
REQ-025 On the edge after the last write of a clear or draw: state=IDLE, wren=0, pronto=1, ocupado=0.
REQ-026 pronto SHALL be high for exactly one cycle per completed operation and SHALL not pulse on aborted operations.
REQ-027 A new request SHALL be accepted no earlier than the edge after the pronto cycle begins, i.e. at the first edge sampled in IDLE.
REQ-028 desenha_req during LIMPA or DESENHA SHALL be ignored and not queued.
REQ-029 limpar=1 during DESENHA SHALL abort the draw and restart at LIMPA with address 0 on that edge; limpar=1 during LIMPA SHALL restart the clear at address 0.
REQ-030 When wren=0, wraddress and data SHALL hold 0.
REQ-031 Default latencies are 307200 write cycles for a clear and 64 write cycles for a draw.

Reset
REQ-032 While reset=1, immediately and independent of CLOCK_50: state=IDLE, wren=0, wraddress=0, data=0, ocupado=0, pronto=0, latched coordinates and cor=0, counters=0.
REQ-033 Reset asserted mid-clear or mid-draw SHALL abandon the operation without a pronto pulse; after release the block SHALL wait in IDLE for a new request.

Verification
REQ-034 Draw coord=(216,240), cor=8'h01 -> 64 consecutive writes, first address 153816, row step 640, last address 158303; pronto one cycle later.
REQ-035 limpar pulse -> 307200 writes, data 0, addresses 0..307199 contiguous, then pronto for one cycle; ocupado high throughout.
REQ-036 Draw coord=(636,476) -> 64 cycles; wren=1 only for columns 636..639 in rows 476..479, 16 writes total; pronto after cycle 64.
REQ-037 limpar and desenha_req asserted on the same edge in IDLE -> LIMPA entered, no pixel of the block written.
REQ-038 limpar asserted on the 10th draw cycle -> draw aborted, no pronto, clear starts at address 0 on that edge; desenha_req asserted during a clear -> ignored.
REQ-039 Reset asserted asynchronously mid-draw -> wren, ocupado, pronto drop to 0 before the next edge; no pronto after release.

Source files
------------

// File: rtl/escritor_rastro.sv
// escritor_rastro: writes the player trail into a frame-sized trail RAM.
// A clear walks every address writing 0. A draw writes one TAM_BLOCO x TAM_BLOCO
// block of code 'cor' at (coord_x, coord_y). Pixels that fall off-screen are skipped.
// Ports:
//   CLOCK_50, reset             clock, asynchronous active-high reset
//   limpar                      clear request; has priority and restarts any operation
//   desenha_req                 block draw request, accepted only in IDLE
//   coord_x, coord_y, cor       block origin and trail code, latched on acceptance
//   wraddress, data, wren       RAM write port (address = x + y*LARGURA)
//   ocupado                     high while an operation is in progress
//   pronto                      one-cycle completion pulse
module escritor_rastro #(
    parameter int unsigned LARGURA   = 640,
    parameter int unsigned ALTURA    = 480,
    parameter int unsigned TAM_BLOCO = 8
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        limpar,
    input  logic        desenha_req,
    input  logic [9:0]  coord_x,
    input  logic [9:0]  coord_y,
    input  logic [7:0]  cor,
    output logic [18:0] wraddress,
    output logic [7:0]  data,
    output logic        wren,
    output logic        ocupado,
    output logic        pronto
);

    localparam int unsigned AW    = 19;
    localparam int unsigned NW    = 20;
    localparam int unsigned CW    = $clog2(TAM_BLOCO + 1);
    localparam int unsigned TOTAL = LARGURA * ALTURA;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] LIMPA   = 2'd1;
    localparam logic [1:0] DESENHA = 2'd2;

    logic [1:0]    state, next_state;
    logic [9:0]    base_x, base_y, next_base_x, next_base_y;
    logic [7:0]    cor_r, next_cor;
    logic [CW-1:0] col, lin, next_col, next_lin;
    logic [NW-1:0] clr_cnt, next_clr_cnt;
    logic [AW-1:0] next_addr;
    logic [7:0]    next_data;
    logic          next_wren, next_pronto;

    // Current pixel source: live inputs on the accepting edge, latched values afterwards
    logic [9:0]    src_x, src_y;
    logic [CW-1:0] src_c, src_l;
    logic [AW-1:0] pix_x, pix_y, pix_addr;
    logic          pix_ok;
    logic [CW-1:0] adv_col, adv_lin;

    always_comb begin
        if (state == IDLE) begin
            src_x = coord_x;
            src_y = coord_y;
            src_c = '0;
            src_l = '0;
        end else begin
            src_x = base_x;
            src_y = base_y;
            src_c = col;
            src_l = lin;
        end
        pix_x    = AW'(src_x) + AW'(src_c);
        pix_y    = AW'(src_y) + AW'(src_l);
        pix_ok   = (pix_x < AW'(LARGURA)) && (pix_y < AW'(ALTURA));
        pix_addr = pix_x + pix_y * AW'(LARGURA);
        // Row-major step; lin reaching TAM_BLOCO marks the block as finished
        if (src_c == CW'(TAM_BLOCO - 1)) begin
            adv_col = '0;
            adv_lin = CW'(src_l + CW'(1));
        end else begin
            adv_col = CW'(src_c + CW'(1));
            adv_lin = src_l;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        next_state   = state;
        next_base_x  = base_x;
        next_base_y  = base_y;
        next_cor     = cor_r;
        next_col     = col;
        next_lin     = lin;
        next_clr_cnt = clr_cnt;
        next_addr    = '0;
        next_data    = '0;
        next_wren    = 1'b0;
        next_pronto  = 1'b0;

        if (limpar) begin
            // Start or restart the clear, writing address 0 on this edge
            next_state   = LIMPA;
            next_wren    = 1'b1;
            next_clr_cnt = NW'(1);
            next_col     = '0;
            next_lin     = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (desenha_req) begin
                        next_state  = DESENHA;
                        next_base_x = coord_x;
                        next_base_y = coord_y;
                        next_cor    = cor;
                        next_wren   = pix_ok;
                        next_addr   = pix_ok ? pix_addr : '0;
                        next_data   = pix_ok ? cor : 8'h00;
                        next_col    = adv_col;
                        next_lin    = adv_lin;
                    end
                end
                LIMPA: begin
                    if (clr_cnt == NW'(TOTAL)) begin
                        next_state   = IDLE;
                        next_pronto  = 1'b1;
                        next_clr_cnt = '0;
                    end else begin
                        next_wren    = 1'b1;
                        next_addr    = AW'(clr_cnt);
                        next_clr_cnt = NW'(clr_cnt + NW'(1));
                    end
                end
                DESENHA: begin
                    if (lin == CW'(TAM_BLOCO)) begin
                        next_state  = IDLE;
                        next_pronto = 1'b1;
                        next_col    = '0;
                        next_lin    = '0;
                    end else begin
                        // Clipped pixels still consume their cycle
                        next_wren = pix_ok;
                        next_addr = pix_ok ? pix_addr : '0;
                        next_data = pix_ok ? cor_r : 8'h00;
                        next_col  = adv_col;
                        next_lin  = adv_lin;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // State and registered outputs
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            base_x    <= '0;
            base_y    <= '0;
            cor_r     <= '0;
            col       <= '0;
            lin       <= '0;
            clr_cnt   <= '0;
            wraddress <= '0;
            data      <= '0;
            wren      <= 1'b0;
            ocupado   <= 1'b0;
            pronto    <= 1'b0;
        end else begin
            state     <= next_state;
            base_x    <= next_base_x;
            base_y    <= next_base_y;
            cor_r     <= next_cor;
            col       <= next_col;
            lin       <= next_lin;
            clr_cnt   <= next_clr_cnt;
            wraddress <= next_addr;
            data      <= next_data;
            wren      <= next_wren;
            ocupado   <= (next_state != IDLE);
            pronto    <= next_pronto;
        end
    end

endmodule

// File: tb/tb_escritor_rastro.sv
// Scoreboard bench: dut_a uses the default 640x480/8 geometry, dut_b a small 24x16/4
// screen so full clears stay short. Stimulus pushes expected writes/pronto events;
// the monitor pops and compares whenever a DUT writes or pulses pronto.
module tb_escritor_rastro;

    typedef struct packed {
        logic        pr;
        logic [18:0] addr;
        logic [7:0]  dat;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_lim = 0, a_req = 0, b_lim = 0, b_req = 0;
    logic [9:0]  a_x = 0, a_y = 0, b_x = 0, b_y = 0;
    logic [7:0]  a_c = 0, b_c = 0;
    logic [18:0] a_wa, b_wa;
    logic [7:0]  a_d, b_d;
    logic        a_wr, b_wr, a_oc, b_oc, a_pr, b_pr;

    ev_t qa[$];
    ev_t qb[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  cyc      = 0;
    int  exp_pr_a = -1;
    int  exp_pr_b = -1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    escritor_rastro dut_a (
        .CLOCK_50(clk), .reset(rst), .limpar(a_lim), .desenha_req(a_req),
        .coord_x(a_x), .coord_y(a_y), .cor(a_c),
        .wraddress(a_wa), .data(a_d), .wren(a_wr), .ocupado(a_oc), .pronto(a_pr)
    );

    escritor_rastro #(.LARGURA(24), .ALTURA(16), .TAM_BLOCO(4)) dut_b (
        .CLOCK_50(clk), .reset(rst), .limpar(b_lim), .desenha_req(b_req),
        .coord_x(b_x), .coord_y(b_y), .cor(b_c),
        .wraddress(b_wa), .data(b_d), .wren(b_wr), .ocupado(b_oc), .pronto(b_pr)
    );

    function automatic int qsize(input int d);
        return (d == 0) ? qa.size() : qb.size();
    endfunction

    task automatic push(input int d, input ev_t e);
        if (d == 0) qa.push_back(e);
        else        qb.push_back(e);
    endtask

    // Reference: every in-range pixel of the block in row-major order, optionally
    // truncated to the first npix cycles, followed by a pronto event when done
    task automatic model_draw(input int d, input int x, input int y, input logic [7:0] c,
                              input int npix, input bit done);
        int w, h, t, k;
        ev_t e;
        w = (d == 0) ? 640 : 24;
        h = (d == 0) ? 480 : 16;
        t = (d == 0) ? 8 : 4;
        k = 0;
        for (int r = 0; r < t; r++) begin
            for (int cc = 0; cc < t; cc++) begin
                if (k < npix && (x + cc) < w && (y + r) < h) begin
                    e.pr = 1'b0; e.addr = 19'((x + cc) + (y + r) * w); e.dat = c;
                    push(d, e);
                end
                k++;
            end
        end
        if (done) begin
            e.pr = 1'b1; e.addr = '0; e.dat = '0;
            push(d, e);
        end
    endtask

    task automatic model_clear(input int d, input int n);
        ev_t e;
        for (int a = 0; a < n; a++) begin
            e.pr = 1'b0; e.addr = 19'(a); e.dat = 8'h00;
            push(d, e);
        end
        e.pr = 1'b1; e.addr = '0; e.dat = '0;
        push(d, e);
    endtask

    task automatic check_eq(input string nm, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", nm, got, exp);
        end
    endtask

    task automatic check_out(input int d, input logic wr, input logic [18:0] a,
                             input logic [7:0] dv, input logic oc, input logic pr);
        ev_t e;
        int  ep;
        if (!(wr || pr)) return;
        n_checks++;
        if (qsize(d) == 0) begin
            n_fail++;
            $display("FAIL unexpected_output dut%0d cyc %0d: wren=%0b addr=%0d data=%0h pronto=%0b, required no activity",
                     d, cyc, wr, a, dv, pr);
            return;
        end
        if (d == 0) e = qa.pop_front();
        else        e = qb.pop_front();
        ep = (d == 0) ? exp_pr_a : exp_pr_b;
        if (e.pr) begin
            if (!pr || wr || oc || cyc != ep) begin
                n_fail++;
                $display("FAIL pronto dut%0d: got pronto=%0b wren=%0b ocupado=%0b cyc=%0d, required pronto=1 wren=0 ocupado=0 cyc=%0d",
                         d, pr, wr, oc, cyc, ep);
            end
        end else if (!wr || pr || a != e.addr || dv != e.dat || !oc) begin
            n_fail++;
            $display("FAIL write dut%0d cyc %0d: got wren=%0b addr=%0d data=%0h ocupado=%0b, required wren=1 addr=%0d data=%0h ocupado=1",
                     d, cyc, wr, a, dv, oc, e.addr, e.dat);
        end
    endtask

    always @(posedge clk) begin
        #1;
        check_out(0, a_wr, a_wa, a_d, a_oc, a_pr);
        check_out(1, b_wr, b_wa, b_d, b_oc, b_pr);
    end

    // One-cycle draw request; coordinates are scrambled afterwards to prove latching
    task automatic draw(input int d, input int x, input int y, input logic [7:0] c);
        @(negedge clk);
        if (d == 0) begin a_req = 1; a_x = 10'(x); a_y = 10'(y); a_c = c; end
        else        begin b_req = 1; b_x = 10'(x); b_y = 10'(y); b_c = c; end
        @(negedge clk);
        if (d == 0) begin
            a_req = 0; a_x = 10'($urandom); a_y = 10'($urandom); a_c = 8'($urandom);
            exp_pr_a = cyc + 64;
        end else begin
            b_req = 0; b_x = 10'($urandom); b_y = 10'($urandom); b_c = 8'($urandom);
            exp_pr_b = cyc + 16;
        end
    endtask

    task automatic drain(input int d);
        int n;
        n = 0;
        while (qsize(d) != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (qsize(d) != 0) begin
            n_fail++;
            $display("FAIL drain_timeout dut%0d: %0d events outstanding, required 0", d, qsize(d));
            if (d == 0) qa.delete();
            else        qb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int x, y;
        logic [7:0] c;

        // Reset values while reset is held, before any clock edge
        #2;
        check_eq("rst_a_wren", int'(a_wr), 0);
        check_eq("rst_a_addr", int'(a_wa), 0);
        check_eq("rst_a_data", int'(a_d), 0);
        check_eq("rst_a_ocupado", int'(a_oc), 0);
        check_eq("rst_a_pronto", int'(a_pr), 0);
        check_eq("rst_b_wren", int'(b_wr), 0);
        check_eq("rst_b_ocupado", int'(b_oc), 0);
        @(negedge clk);
        rst = 0;
        repeat (2) @(negedge clk);

        // Centre draw: addresses 153816 .. 158303, pronto after 64 cycles
        model_draw(0, 216, 240, 8'h01, 64, 1);
        draw(0, 216, 240, 8'h01);
        drain(0);

        // Corner draw: only 4x4 pixels on screen, still 64 cycles
        model_draw(0, 636, 476, 8'h02, 64, 1);
        draw(0, 636, 476, 8'h02);
        drain(0);

        // Full clear of the small screen with a draw request ignored midway
        model_clear(1, 384);
        @(negedge clk); b_lim = 1;
        @(negedge clk); b_lim = 0; exp_pr_b = cyc + 384;
        repeat (30) @(negedge clk);
        b_req = 1; b_x = 10'd1; b_y = 10'd1; b_c = 8'h07;
        @(negedge clk); b_req = 0;
        drain(1);

        // Simultaneous limpar and desenha_req in IDLE: clear wins, no block pixels
        model_clear(1, 384);
        @(negedge clk); b_lim = 1; b_req = 1; b_x = 10'd3; b_y = 10'd2; b_c = 8'h09;
        @(negedge clk); b_lim = 0; b_req = 0; exp_pr_b = cyc + 384;
        drain(1);

        // limpar on the 10th draw cycle aborts the draw after 9 pixels
        model_draw(1, 2, 3, 8'h03, 9, 0);
        model_clear(1, 384);
        draw(1, 2, 3, 8'h03);
        repeat (8) @(negedge clk);
        b_lim = 1;
        @(negedge clk); b_lim = 0; exp_pr_b = cyc + 384;
        drain(1);

        // Randomized draws on the small screen, many partially off-screen
        for (int i = 0; i < 12; i++) begin
            x = int'($urandom_range(0, 27));
            y = int'($urandom_range(0, 19));
            c = 8'($urandom);
            model_draw(1, x, y, c, 16, 1);
            draw(1, x, y, c);
            drain(1);
        end

        // Randomized draws on the full-size screen
        for (int i = 0; i < 4; i++) begin
            x = int'($urandom_range(0, 1023));
            y = int'($urandom_range(0, 1023));
            c = 8'($urandom);
            model_draw(0, x, y, c, 64, 1);
            draw(0, x, y, c);
            drain(0);
        end

        // Asynchronous reset after 5 pixels of a draw: outputs drop before the next edge
        model_draw(0, 300, 200, 8'h05, 5, 0);
        draw(0, 300, 200, 8'h05);
        repeat (4) @(posedge clk);
        #3 rst = 1;
        #1;
        check_eq("async_rst_wren", int'(a_wr), 0);
        check_eq("async_rst_ocupado", int'(a_oc), 0);
        check_eq("async_rst_pronto", int'(a_pr), 0);
        check_eq("async_rst_addr", int'(a_wa), 0);
        check_eq("async_rst_pending", qa.size(), 0);
        exp_pr_a = -1;
        @(negedge clk); rst = 0;
        repeat (100) @(negedge clk);
        check_eq("post_rst_idle_ocupado", int'(a_oc), 0);

        // The block accepts a fresh request after the reset
        model_draw(0, 0, 0, 8'h0A, 64, 1);
        draw(0, 0, 0, 8'h0A);
        drain(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
